// File: rtl/fetch.sv
// fetch: instruction fetch stage of the five-stage RV32I pipeline.
// Owns the PC, drives the instruction memory address and fills the IF/ID register.
// Optional feature macro: FETCH_MISALIGN_CHK_EN. When defined, a redirect to a target that is
// not word aligned produces one IF/ID fault marker and then halts fetch.
module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_vld,
    output logic        o_misalign,
    output logic        o_halted
);

    // StFault lasts one cycle: it emits the misaligned-redirect marker before halting.
    typedef enum logic [1:0] {StRun, StFault, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] nxt_pc_q, nxt_pc_d;
    logic        vld_q, vld_d;
    logic [31:0] redirect_tgt;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    logic tgt_misaligned;

    assign redirect_tgt   = i_redirect_pc;
    assign tgt_misaligned = |i_redirect_pc[1:0];
    assign o_misalign     = misalign_q;
`else
    logic unused_redirect_lsbs;

    // Low target bits are dropped so the PC always stays word aligned.
    assign redirect_tgt         = {i_redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
    assign o_misalign           = 1'b0;
`endif

    // Next-state logic: defaults hold everything, which is also the i_hold behaviour.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        ifid_pc_d = ifid_pc_q;
        nxt_pc_d  = nxt_pc_q;
        vld_d     = vld_q;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            StRun: begin
                if (i_halt) begin
                    state_d = StHalt;
                    inst_d  = NOP_INST;
                    vld_d   = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                    misalign_d = 1'b0;
`endif
                end else if (i_redirect) begin
                    // Redirect beats hold: the held instruction is on the wrong path.
                    pc_d   = redirect_tgt;
                    inst_d = NOP_INST;
                    vld_d  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                    misalign_d = 1'b0;
                    if (tgt_misaligned) begin
                        state_d = StFault;
                    end
`endif
                end else if (!i_hold) begin
                    inst_d    = i_imem_rdata;
                    ifid_pc_d = pc_q;
                    nxt_pc_d  = pc_q + 32'd4;
                    vld_d     = 1'b1;
                    pc_d      = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_CHK_EN
                    misalign_d = 1'b0;
`endif
                end
            end
            StFault: begin
                state_d   = StHalt;
                inst_d    = NOP_INST;
                ifid_pc_d = pc_q;
                nxt_pc_d  = pc_q + 32'd4;
                vld_d     = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
                misalign_d = 1'b1;
`endif
            end
            default: begin
                inst_d = NOP_INST;
                vld_d  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
                misalign_d = 1'b0;
`endif
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StRun;
            pc_q      <= RESET_ADDR;
            inst_q    <= NOP_INST;
            ifid_pc_q <= 32'd0;
            nxt_pc_q  <= 32'd0;
            vld_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            ifid_pc_q <= ifid_pc_d;
            nxt_pc_q  <= nxt_pc_d;
            vld_q     <= vld_d;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign o_imem_raddr = pc_q;
    assign o_inst       = inst_q;
    assign o_pc         = ifid_pc_q;
    assign o_nxt_pc     = nxt_pc_q;
    assign o_vld        = vld_q;
    assign o_halted     = (state_q == StHalt);

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for the fetch stage.
// Each cycle the expected IF/ID contents are pushed when inputs are driven and popped after
// the clock edge; directed checks cover the reset, hold, redirect, wrap and halt cases.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic [31:0] imem_raddr, imem_rdata, inst, pc, nxt_pc;
    logic        vld, misalign, halted;

    always #5 clk = ~clk;

    // Word k lives at address 4k; tagged so it never looks like a NOP or an address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h5A00_0000 ^ {2'b00, a[31:2]};
    endfunction

    assign imem_rdata = imem_word(imem_raddr);

    fetch #(
        .RESET_ADDR(RST_PC),
        .NOP_INST  (NOP)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_hold       (hold),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .i_halt       (halt),
        .o_imem_raddr (imem_raddr),
        .i_imem_rdata (imem_rdata),
        .o_inst       (inst),
        .o_pc         (pc),
        .o_nxt_pc     (nxt_pc),
        .o_vld        (vld),
        .o_misalign   (misalign),
        .o_halted     (halted)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] nxt;
        logic [31:0] raddr;
        logic        vld;
        logic        mis;
        logic        halted;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model of the stage (0 run, 1 fault marker pending, 2 halted).
    logic [31:0] m_pc, m_inst, m_ifpc, m_nxt;
    logic        m_vld, m_mis;
    int          m_st;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_bubble();
        m_inst = NOP;
        m_vld  = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic step(input logic r, input logic h, input logic rd, input logic [31:0] tgt,
                        input logic hl);
        exp_t e;
        @(negedge clk);
        rst = r; hold = h; redirect = rd; redirect_pc = tgt; halt = hl;
        if (r) begin
            m_pc = RST_PC; m_inst = NOP; m_ifpc = 32'd0; m_nxt = 32'd0;
            m_vld = 1'b0; m_mis = 1'b0; m_st = 0;
        end else if (m_st == 2) begin
            model_bubble();
        end else if (m_st == 1) begin
            m_st = 2; m_inst = NOP; m_ifpc = m_pc; m_nxt = m_pc + 32'd4;
            m_vld = 1'b1; m_mis = 1'b1;
        end else if (hl) begin
            m_st = 2;
            model_bubble();
        end else if (rd) begin
            model_bubble();
`ifdef FETCH_MISALIGN_CHK_EN
            m_pc = tgt;
            if (tgt[1:0] != 2'b00) m_st = 1;
`else
            m_pc = tgt & 32'hFFFF_FFFC;
`endif
        end else if (!h) begin
            m_inst = imem_word(m_pc); m_ifpc = m_pc; m_nxt = m_pc + 32'd4;
            m_vld = 1'b1; m_mis = 1'b0; m_pc = m_pc + 32'd4;
        end
        e.inst = m_inst; e.pc = m_ifpc; e.nxt = m_nxt; e.raddr = m_pc;
        e.vld = m_vld; e.mis = m_mis; e.halted = (m_st == 2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_inst", inst, e.inst);
        check_eq("sb_pc", pc, e.pc);
        check_eq("sb_nxt_pc", nxt_pc, e.nxt);
        check_eq("sb_raddr", imem_raddr, e.raddr);
        check_eq("sb_vld", {31'd0, vld}, {31'd0, e.vld});
        check_eq("sb_misalign", {31'd0, misalign}, {31'd0, e.mis});
        check_eq("sb_halted", {31'd0, halted}, {31'd0, e.halted});
    endtask

    task automatic adv();
        step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc_before;

        // Reset values, then straight-line fetch.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_raddr", imem_raddr, RST_PC);
        check_eq("rst_vld", {31'd0, vld}, 32'd0);
        repeat (4) adv();
        check_eq("adv_pc", pc, 32'h0000_000C);
        check_eq("adv_nxt", nxt_pc, 32'h0000_0010);
        check_eq("adv_inst", inst, 32'h5A00_0003);
        check_eq("adv_vld", {31'd0, vld}, 32'd1);

        // Three-cycle hold while IF/ID holds pc 0x8.
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) adv();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
            check_eq("hold_pc", pc, 32'h0000_0008);
            check_eq("hold_raddr", imem_raddr, 32'h0000_000C);
        end
        adv();
        check_eq("rel_pc0", pc, 32'h0000_000C);
        adv();
        check_eq("rel_pc1", pc, 32'h0000_0010);

        // Redirect overrides hold; exactly one bubble.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        check_eq("redir_bubble_vld", {31'd0, vld}, 32'd0);
        check_eq("redir_bubble_inst", inst, NOP);
        adv();
        check_eq("redir_pc", pc, 32'h0000_0100);
        check_eq("redir_vld", {31'd0, vld}, 32'd1);

        // Mixed hold/redirect traffic with aligned targets.
        for (int i = 0; i < 40; i++) begin
            step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                 32'($urandom_range(0, 255)) << 2, 1'b0);
        end

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        adv();
        check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
        check_eq("wrap_nxt", nxt_pc, 32'h0000_0000);
        adv();
        check_eq("wrap_pc_next", pc, 32'h0000_0000);

        // Misaligned redirect target.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b0);
        adv();
`ifdef FETCH_MISALIGN_CHK_EN
        check_eq("mis_flag", {31'd0, misalign}, 32'd1);
        check_eq("mis_vld", {31'd0, vld}, 32'd1);
        check_eq("mis_pc", pc, 32'h0000_0102);
        check_eq("mis_halted", {31'd0, halted}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
`else
        check_eq("mis_pc", pc, 32'h0000_0100);
        check_eq("mis_flag", {31'd0, misalign}, 32'd0);
`endif

        // Halt wins over a simultaneous redirect; later inputs are ignored.
        adv();
        pc_before = m_pc;
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
        check_eq("halt_flag", {31'd0, halted}, 32'd1);
        check_eq("halt_vld", {31'd0, vld}, 32'd0);
        check_eq("halt_raddr", imem_raddr, pc_before);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'h0000_0300, 1'($urandom_range(0, 1)));
            check_eq("halted_vld", {31'd0, vld}, 32'd0);
            check_eq("halted_raddr", imem_raddr, pc_before);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        check_eq("halt_rst_raddr", imem_raddr, RST_PC);
        check_eq("halt_rst_flag", {31'd0, halted}, 32'd0);
        adv();
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
